adder_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one 32-bit carry-lookahead adder between

---
 rtl/adder_rr_scheduler.sv | 94 +++++++++
 tb/tb_adder_rr_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one carry-lookahead adder across NREQ requesters.
// Define ADD_OVF_EN to add the registered signed-overflow output resp_ovf.
module adder_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  output logic [IDW-1:0]        resp_id
`ifdef ADD_OVF_EN
  ,
  output logic                  resp_ovf
`endif
);
  localparam logic [0:0] EMPTY = 1'b0, FULL = 1'b1;
  logic [0:0] state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, gid, id_q;
  logic [WIDTH-1:0] a, b, g, p, gk, pk, sum, sum_q;
  logic found, can_accept, grant, cin, cout, cout_q;
  int idx;
  always_comb begin
    found = 1'b0;
    gid = '0;
    idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid = IDW'(idx);
      end
    end
  end
  // rst_n gates the grant so nothing is accepted while reset is held
  assign can_accept = rst_n & ((state_q == EMPTY) | resp_ready);
  assign grant = can_accept & found;
  assign req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << gid) : '0;
  assign ptr_d = grant ? ((gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1) : ptr_q;
  assign state_d = grant ? FULL : (resp_ready ? EMPTY : state_q);
  assign a = req_a[int'(gid)*WIDTH +: WIDTH];
  assign b = req_b[int'(gid)*WIDTH +: WIDTH];
  assign cin = req_cin[gid];
  // Kogge-Stone prefix carries; cin is folded into bit 0's generate
  always_comb begin
    g = a & b;
    p = a ^ b;
    gk = g;
    pk = p;
    gk[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < WIDTH; d = d * 2)
      for (int i = WIDTH - 1; i >= d; i--) begin
        gk[i] = gk[i] | (pk[i] & gk[i-d]);
        pk[i] = pk[i] & pk[i-d];
      end
    sum = p ^ {gk[WIDTH-2:0], cin};
    cout = gk[WIDTH-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q <= '0;
      sum_q <= '0;
      cout_q <= 1'b0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      if (grant) begin
        sum_q <= sum;
        cout_q <= cout;
        id_q <= gid;
      end
    end
  assign resp_valid = (state_q == FULL);
  assign resp_sum = sum_q;
  assign resp_cout = cout_q;
  assign resp_id = id_q;
`ifdef ADD_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (grant) ovf_q <= (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  assign resp_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed stimulus with a reference model and result scoreboard.
module tb_adder_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] req_valid, req_ready, req_cin;
  logic [127:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_cout;
  logic [31:0] resp_sum;
  logic [1:0] resp_id;
`ifdef ADD_OVF_EN
  logic resp_ovf;
`endif
  typedef struct {
    logic [31:0] sum;
    logic cout;
    logic [1:0] id;
    logic ovf;
  } exp_t;
  exp_t q[$];
  int pass_cnt = 0, total_cnt = 0;
  logic model_full = 1'b0;
  int mptr = 0;

  adder_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_id(resp_id)
`ifdef ADD_OVF_EN
    , .resp_ovf(resp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++)
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic c);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_cin[i] = c;
  endtask

  // Checks one cycle against the model, then advances past the next rising edge.
  task automatic cycle();
    int w;
    logic [3:0] eg;
    logic [32:0] full_sum;
    logic [31:0] oa, ob;
    exp_t e;
    #2;
    w = (!model_full || resp_ready) ? pick(req_valid, mptr) : -1;
    eg = (w >= 0) ? 4'(1 << w) : 4'b0;
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("resp_valid", 64'(resp_valid), 64'(model_full));
    if (model_full && q.size() > 0) begin
      chk("resp_sum", 64'(resp_sum), 64'(q[0].sum));
      chk("resp_cout", 64'(resp_cout), 64'(q[0].cout));
      chk("resp_id", 64'(resp_id), 64'(q[0].id));
`ifdef ADD_OVF_EN
      chk("resp_ovf", 64'(resp_ovf), 64'(q[0].ovf));
`endif
      if (resp_ready) void'(q.pop_front());
    end
    if (w >= 0) begin
      oa = req_a[w*32 +: 32];
      ob = req_b[w*32 +: 32];
      full_sum = {1'b0, oa} + {1'b0, ob} + 33'(req_cin[w]);
      e.sum = full_sum[31:0];
      e.cout = full_sum[32];
      e.id = 2'(w);
      e.ovf = (oa[31] == ob[31]) && (full_sum[31] != oa[31]);
      q.push_back(e);
      mptr = (w + 1) % 4;
      model_full = 1'b1;
    end else if (resp_ready) model_full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    model_full = 1'b0;
    mptr = 0;
  endtask

  initial begin
    logic [3:0] fair[5];
    fair = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0;
    req_valid = 4'b0001;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    resp_ready = 1'b0;
    #2;
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_sum", 64'(resp_sum), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(0, 32'd5, 32'd7, 1'b1);
    cycle();
    req_valid = 4'b0000;
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midfull_rst_valid", 64'(resp_valid), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b0001;
    #2;
    chk("post_rst_grant", 64'(req_ready), 64'b0001);
    cycle();
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    #2;
    chk("single_sum", 64'(resp_sum), 64'd13);
    chk("single_cout", 64'(resp_cout), 64'd0);
    cycle();
    req_valid = 4'b1000;
    set_op(3, 32'd100, 32'hFFFF_FFFF, 1'b0);
    cycle();
    set_op(0, 32'h0000_0011, 32'h0000_0022, 1'b0);
    set_op(1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    set_op(2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    set_op(3, 32'hFFFF_FFF0, 32'h0000_0010, 1'b1);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("fair_grant", 64'(req_ready), 64'(fair[i]));
      cycle();
    end
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      cycle();
    end
    resp_ready = 1'b1;
    #2;
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    cycle();
    req_valid = 4'b0001;
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    cycle();
    #2;
    chk("wrap_sum", 64'(resp_sum), 64'd0);
    chk("wrap_cout", 64'(resp_cout), 64'd1);
    req_valid = 4'b0100;
    set_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0);
    cycle();
    req_valid = 4'b0001;
    set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    cycle();
    set_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    cycle();
    req_valid = 4'b0000;
    for (int i = 0; i < 4 && model_full; i++) cycle();
    chk("sb_drained", 64'(q.size()), 64'(0));
    chk("idle_valid", 64'(resp_valid), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
